writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL provide CLK  input  1  single clock; all state updates on posedge CLK.
REQ-002 SHALL provide RESETn  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide aluValid  input  1  ALU result present this cycle.
REQ-004 SHALL provide aluRd  input  5  ALU destination register.
REQ-005 SHALL provide aluData  input  64  ALU result.
REQ-006 SHALL provide memValid  input  1  load result present this cycle.
REQ-007 SHALL provide memRd  input  5  load destination register.
REQ-008 SHALL provide memData  input  64  load result.
REQ-009 SHALL provide qRn, qRm  input  5 each  forwarding lookup addresses.
REQ-010 SHALL provide Rd  output  5  register-file write address.
REQ-011 SHALL provide dataWrite  output  64  register-file write data.
REQ-012 SHALL provide regWR  output  1  register-file write enable; consumed by register file on negedge CLK.
REQ-013 SHALL provide stall  output  1  upstream must not present new results.
REQ-014 SHALL provide hitRn, hitRm  output  1 each  pending write exists for qRn/qRm.
REQ-015 SHALL provide fwdRn, fwdRm  output  64 each  youngest pending data for qRn/qRm.
REQ-016 SHALL provide count  output  3  queue occupancy, 0..4.
REQ-017 SHALL provide overflow  output  1  sticky drop flag.

Function
REQ-018 SHALL hold a 4-entry FIFO of {Rd[4:0], data[63:0]} plus one output stage driving Rd/dataWrite/regWR.
REQ-019 SHALL treat memValid as older than aluValid when both asserted: mem entry enqueued first, alu entry behind it, same edge.
REQ-020 SHALL discard any valid input whose Rd == 31 (XZR); it is not enqueued, not counted, not forwarded.
REQ-021 SHALL pop the head each posedge when count > 0: output stage loads head, regWR=1; when count == 0, regWR=0 and Rd/dataWrite hold previous values.
REQ-022 SHALL allow push(es) and pop on the same edge; new count = count - pop + pushes.
REQ-023 SHALL give latency of exactly 2 edges from enqueue edge to regWR high, for an entry entering an empty queue.
REQ-024 SHALL assert stall combinationally when count >= 3.
REQ-025 SHALL, when pushes exceed free slots after the same-edge pop, accept mem before alu, drop the excess, and set overflow=1 until reset.
REQ-026 SHALL compute hitRx/fwdRx combinationally over FIFO entries and output stage (when regWR=1); youngest match wins: tail-most FIFO entry, then toward head, then output stage.
REQ-027 SHALL drive hitRx=0 and fwdRx=0 when no match or qRx == 31.
REQ-028 SHALL wrap read/write pointers modulo 4.
REQ-029 SHALL preserve program order: register-file writes occur in enqueue order; same Rd written twice yields last value.

Reset
REQ-030 SHALL, on posedge CLK with RESETn=0, clear pointers, count=0, regWR=0, Rd=0, dataWrite=0, overflow=0; all inputs ignored that edge.
REQ-031 SHALL, on reset mid-operation, discard all queued entries; no regWR pulse follows for them.

Verification
REQ-032 SHALL verify single write: empty queue, memValid=1 memRd=5 memData=0xAA for one cycle -> regWR=1 Rd=5 dataWrite=0xAA exactly 2 edges later for one cycle; count 1 then 0.
REQ-033 SHALL verify ordering: memValid(Rd=3,0x11) and aluValid(Rd=3,0x22) same edge -> Rd=3/0x11 written, then Rd=3/0x22 next cycle; hitRn with qRn=3 returns 0x22 while both pending.
REQ-034 SHALL verify XZR: aluValid=1 aluRd=31 -> count stays 0, regWR stays 0, hitRn=0 for qRn=31.
REQ-035 SHALL verify overflow: count=4, both valids asserted -> mem accepted, alu dropped, count=4, overflow=1 and stays 1; stall=1 throughout.
REQ-036 SHALL verify stall threshold: fill to count=3 -> stall=1; drain to 2 -> stall=0 same cycle.
REQ-037 SHALL verify reset mid-operation: count=3, RESETn=0 one edge -> count=0, regWR=0, overflow=0, no further writes.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer results and forwarding lookups in, register-file
// write port and status out.
interface writeback_queue_if;
   logic        aluValid;
   logic [4:0]  aluRd;
   logic [63:0] aluData;
   logic        memValid;
   logic [4:0]  memRd;
   logic [63:0] memData;
   logic [4:0]  qRn;
   logic [4:0]  qRm;
   logic [4:0]  Rd;
   logic [63:0] dataWrite;
   logic        regWR;
   logic        stall;
   logic        hitRn;
   logic        hitRm;
   logic [63:0] fwdRn;
   logic [63:0] fwdRm;
   logic [2:0]  count;
   logic        overflow;

   modport master (
      output aluValid, aluRd, aluData, memValid, memRd, memData, qRn, qRm,
      input  Rd, dataWrite, regWR, stall, hitRn, hitRm, fwdRn, fwdRm, count, overflow
   );

   modport slave (
      input  aluValid, aluRd, aluData, memValid, memRd, memData, qRn, qRm,
      output Rd, dataWrite, regWR, stall, hitRn, hitRm, fwdRn, fwdRm, count, overflow
   );
endinterface

// File: rtl/writeback_queue.sv
// 4-entry writeback FIFO with a register-file output stage and youngest-match
// forwarding. Load results are ordered ahead of ALU results on the same edge.
module writeback_queue (
   input logic             CLK,
   input logic             RESETn,
   writeback_queue_if.slave wb
);

   localparam logic [4:0] Xzr = 5'd31;

   logic [4:0]  rdMem   [4];
   logic [63:0] dataMem [4];

   logic [1:0]  rdPtrQ, rdPtrD;
   logic [1:0]  wrPtrQ, wrPtrD;
   logic [2:0]  countQ, countD;
   logic        overflowQ, overflowD;
   logic [4:0]  rdQ;
   logic [63:0] dataQ;
   logic        regWrQ;

   logic        pop;
   logic        memOk, aluOk;
   logic        acceptMem, acceptAlu;
   logic [2:0]  free;
   logic [1:0]  aluPtr;

   always_comb begin
      pop       = (countQ != 3'd0);
      memOk     = wb.memValid && (wb.memRd != Xzr);
      aluOk     = wb.aluValid && (wb.aluRd != Xzr);
      // Slots freed by this edge's pop are reusable on the same edge.
      free      = 3'd4 - countQ + {2'b0, pop};
      acceptMem = memOk && (free != 3'd0);
      acceptAlu = aluOk && (free > {2'b0, acceptMem});
      aluPtr    = wrPtrQ + {1'b0, acceptMem};
      rdPtrD    = rdPtrQ + {1'b0, pop};
      wrPtrD    = wrPtrQ + {1'b0, acceptMem} + {1'b0, acceptAlu};
      countD    = countQ - {2'b0, pop} + {2'b0, acceptMem} + {2'b0, acceptAlu};
      overflowD = overflowQ || (memOk && !acceptMem) || (aluOk && !acceptAlu);
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         rdPtrQ    <= 2'd0;
         wrPtrQ    <= 2'd0;
         countQ    <= 3'd0;
         overflowQ <= 1'b0;
         rdQ       <= 5'd0;
         dataQ     <= 64'd0;
         regWrQ    <= 1'b0;
      end else begin
         rdPtrQ    <= rdPtrD;
         wrPtrQ    <= wrPtrD;
         countQ    <= countD;
         overflowQ <= overflowD;
         regWrQ    <= pop;
         if (pop) begin
            rdQ   <= rdMem[rdPtrQ];
            dataQ <= dataMem[rdPtrQ];
         end
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge CLK) begin
      if (RESETn) begin
         if (acceptMem) begin
            rdMem[wrPtrQ]   <= wb.memRd;
            dataMem[wrPtrQ] <= wb.memData;
         end
         if (acceptAlu) begin
            rdMem[aluPtr]   <= wb.aluRd;
            dataMem[aluPtr] <= wb.aluData;
         end
      end
   end

   logic        hitN, hitM;
   logic [63:0] fwdN, fwdM;
   logic [1:0]  idx;

   // Oldest first, so later (younger) matches overwrite earlier ones.
   always_comb begin
      hitN = 1'b0;
      hitM = 1'b0;
      fwdN = 64'd0;
      fwdM = 64'd0;
      idx  = 2'd0;
      if (regWrQ && (rdQ == wb.qRn)) begin
         hitN = 1'b1;
         fwdN = dataQ;
      end
      if (regWrQ && (rdQ == wb.qRm)) begin
         hitM = 1'b1;
         fwdM = dataQ;
      end
      for (int i = 0; i < 4; i++) begin
         idx = rdPtrQ + 2'(i);
         if (3'(i) < countQ) begin
            if (rdMem[idx] == wb.qRn) begin
               hitN = 1'b1;
               fwdN = dataMem[idx];
            end
            if (rdMem[idx] == wb.qRm) begin
               hitM = 1'b1;
               fwdM = dataMem[idx];
            end
         end
      end
      if (wb.qRn == Xzr) begin
         hitN = 1'b0;
         fwdN = 64'd0;
      end
      if (wb.qRm == Xzr) begin
         hitM = 1'b0;
         fwdM = 64'd0;
      end
   end

   assign wb.Rd        = rdQ;
   assign wb.dataWrite = dataQ;
   assign wb.regWR     = regWrQ;
   assign wb.stall     = (countQ >= 3'd3);
   assign wb.hitRn     = hitN;
   assign wb.hitRm     = hitM;
   assign wb.fwdRn     = fwdN;
   assign wb.fwdRm     = fwdM;
   assign wb.count     = countQ;
   assign wb.overflow  = overflowQ;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: single write, ordering, XZR, overflow,
// stall threshold and mid-operation reset.
module tb_writeback_queue;

   logic clk;
   logic rstN;
   int   totalChecks;
   int   badChecks;

   writeback_queue_if wb ();

   writeback_queue dut (
      .CLK    (clk),
      .RESETn (rstN),
      .wb     (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                        input logic av, input logic [4:0] ar, input logic [63:0] ad);
      wb.memValid = mv;
      wb.memRd    = mr;
      wb.memData  = md;
      wb.aluValid = av;
      wb.aluRd    = ar;
      wb.aluData  = ad;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
   endtask

   task automatic checkOut(input string tag, input logic wr, input logic [4:0] rd,
                           input logic [63:0] d, input logic [2:0] cnt);
      checkVal({tag, ".regWR"}, 64'(wb.regWR), 64'(wr));
      if (wr) begin
         checkVal({tag, ".Rd"}, 64'(wb.Rd), 64'(rd));
         checkVal({tag, ".data"}, wb.dataWrite, d);
      end
      checkVal({tag, ".count"}, 64'(wb.count), 64'(cnt));
   endtask

   initial begin
      totalChecks = 0;
      badChecks   = 0;
      idle();
      wb.qRn = 5'd0;
      wb.qRm = 5'd0;
      rstN = 1'b0;
      tick();
      tick();
      rstN = 1'b1;

      // Reset state
      checkVal("rst.count", 64'(wb.count), 64'd0);
      checkVal("rst.regWR", 64'(wb.regWR), 64'd0);
      checkVal("rst.Rd", 64'(wb.Rd), 64'd0);
      checkVal("rst.data", wb.dataWrite, 64'd0);
      checkVal("rst.overflow", 64'(wb.overflow), 64'd0);
      checkVal("rst.stall", 64'(wb.stall), 64'd0);

      // Single write
      drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      wb.qRn = 5'd5;
      #1;
      checkOut("single.e0", 1'b0, 5'd0, 64'd0, 3'd1);
      checkVal("single.hit0", 64'(wb.hitRn), 64'd1);
      checkVal("single.fwd0", wb.fwdRn, 64'hAA);
      tick();
      checkOut("single.e1", 1'b1, 5'd5, 64'hAA, 3'd0);
      checkVal("single.hitOut", 64'(wb.hitRn), 64'd1);
      tick();
      checkOut("single.e2", 1'b0, 5'd0, 64'd0, 3'd0);
      checkVal("single.holdRd", 64'(wb.Rd), 64'd5);
      checkVal("single.holdData", wb.dataWrite, 64'hAA);
      checkVal("single.hitGone", 64'(wb.hitRn), 64'd0);

      // Ordering, same Rd from mem and alu on one edge
      drive(1'b1, 5'd3, 64'h11, 1'b1, 5'd3, 64'h22);
      tick();
      idle();
      wb.qRn = 5'd3;
      #1;
      checkOut("order.e0", 1'b0, 5'd0, 64'd0, 3'd2);
      checkVal("order.hit", 64'(wb.hitRn), 64'd1);
      checkVal("order.fwd", wb.fwdRn, 64'h22);
      tick();
      checkOut("order.e1", 1'b1, 5'd3, 64'h11, 3'd1);
      checkVal("order.fwd1", wb.fwdRn, 64'h22);
      tick();
      checkOut("order.e2", 1'b1, 5'd3, 64'h22, 3'd0);
      tick();
      checkOut("order.e3", 1'b0, 5'd0, 64'd0, 3'd0);

      // XZR discard
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'h55);
      wb.qRn = 5'd31;
      tick();
      idle();
      #1;
      checkOut("xzr.e0", 1'b0, 5'd0, 64'd0, 3'd0);
      checkVal("xzr.hit", 64'(wb.hitRn), 64'd0);
      checkVal("xzr.fwd", wb.fwdRn, 64'd0);
      tick();
      checkOut("xzr.e1", 1'b0, 5'd0, 64'd0, 3'd0);

      // Overflow and stall threshold
      drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
      tick();
      checkOut("ovf.e0", 1'b0, 5'd0, 64'd0, 3'd2);
      checkVal("ovf.stall0", 64'(wb.stall), 64'd0);
      drive(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104);
      tick();
      checkOut("ovf.e1", 1'b1, 5'd1, 64'h101, 3'd3);
      checkVal("ovf.stall1", 64'(wb.stall), 64'd1);
      drive(1'b1, 5'd5, 64'h105, 1'b1, 5'd6, 64'h106);
      tick();
      checkOut("ovf.e2", 1'b1, 5'd2, 64'h102, 3'd4);
      checkVal("ovf.flag2", 64'(wb.overflow), 64'd0);
      drive(1'b1, 5'd7, 64'h107, 1'b1, 5'd8, 64'h108);
      tick();
      idle();
      wb.qRn = 5'd7;
      wb.qRm = 5'd8;
      #1;
      checkOut("ovf.e3", 1'b1, 5'd3, 64'h103, 3'd4);
      checkVal("ovf.flag3", 64'(wb.overflow), 64'd1);
      checkVal("ovf.stall3", 64'(wb.stall), 64'd1);
      checkVal("ovf.memKept", wb.fwdRn, 64'h107);
      checkVal("ovf.aluDropped", 64'(wb.hitRm), 64'd0);
      tick();
      checkOut("ovf.e4", 1'b1, 5'd4, 64'h104, 3'd3);
      checkVal("ovf.stall4", 64'(wb.stall), 64'd1);
      tick();
      checkOut("ovf.e5", 1'b1, 5'd5, 64'h105, 3'd2);
      checkVal("ovf.stall5", 64'(wb.stall), 64'd0);
      tick();
      checkOut("ovf.e6", 1'b1, 5'd6, 64'h106, 3'd1);
      tick();
      checkOut("ovf.e7", 1'b1, 5'd7, 64'h107, 3'd0);
      tick();
      checkOut("ovf.e8", 1'b0, 5'd0, 64'd0, 3'd0);
      checkVal("ovf.sticky", 64'(wb.overflow), 64'd1);

      // Reset mid-operation
      drive(1'b1, 5'd9, 64'h201, 1'b1, 5'd10, 64'h202);
      tick();
      drive(1'b1, 5'd11, 64'h203, 1'b1, 5'd12, 64'h204);
      tick();
      checkVal("mid.count", 64'(wb.count), 64'd3);
      checkVal("mid.stall", 64'(wb.stall), 64'd1);
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      idle();
      #1;
      checkOut("mid.rst", 1'b0, 5'd0, 64'd0, 3'd0);
      checkVal("mid.overflow", 64'(wb.overflow), 64'd0);
      checkVal("mid.Rd", 64'(wb.Rd), 64'd0);
      checkVal("mid.data", wb.dataWrite, 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOut("mid.after", 1'b0, 5'd0, 64'd0, 3'd0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
